move_direction_controller: RTL

Converts the four raw direction buttons into a registered one-hot `move_direction` command and a per-game-tick `move_strobe`, which together feed the position update stage. It synchronises and debounces the buttons. It buffers the most recent press as a pending turn and applies that turn on the first game tick where `valid_moves` permits it. Otherwise it continues in the current heading, or stops against a wall.

---
 rtl/move_direction_controller.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/move_direction_controller.sv
`timescale 1ns/1ps
// Button-driven movement command: synchronise and debounce the buttons, buffer the latest
// press as a pending turn, and resolve heading/strobe once per game tick.
module move_direction_controller #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned TICK_CYCLES     = 1666667,
   parameter int unsigned PENDING_TICKS   = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic       btn_right,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic [3:0] valid_moves,
   output logic [3:0] move_direction,
   output logic       move_strobe,
   output logic [3:0] pending_dir
);

   localparam int unsigned TICK_W = $clog2(TICK_CYCLES + 1);
   localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned AGE_W  = $clog2(PENDING_TICKS + 1);

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [AGE_W-1:0]  AGE_LAST  = AGE_W'(PENDING_TICKS - 1);

   localparam logic [3:0] DIR_RIGHT = 4'b0001;
   localparam logic [3:0] DIR_UP    = 4'b0010;
   localparam logic [3:0] DIR_DOWN  = 4'b0100;
   localparam logic [3:0] DIR_LEFT  = 4'b1000;

   typedef enum logic {
      STOPPED = 1'b0,
      MOVING  = 1'b1
   } state_t;

   logic [3:0]        btn_raw;
   logic [3:0]        sync1;
   logic [3:0]        sync2;
   logic [3:0]        stable;
   logic [3:0]        stable_d;
   logic [DB_W-1:0]   db_cnt [4];
   logic [3:0]        press;
   logic [3:0]        press_dir;
   logic [TICK_W-1:0] tick_cnt;
   logic              tick;
   logic [AGE_W-1:0]  age;
   state_t            state;

   assign btn_raw = {btn_left, btn_down, btn_up, btn_right};

   // Two-flop synchroniser plus per-button debounce counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1    <= '0;
         sync2    <= '0;
         stable   <= '0;
         stable_d <= '0;
         for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
      end else begin
         sync1    <= btn_raw;
         sync2    <= sync1;
         stable_d <= stable;
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] != stable[i]) begin
               if (db_cnt[i] == DB_LAST) begin
                  stable[i] <= ~stable[i];
                  db_cnt[i] <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + DB_W'(1);
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   assign press = stable & ~stable_d;

   // Simultaneous presses resolve UP > DOWN > LEFT > RIGHT.
   always_comb begin
      press_dir = 4'b0000;
      if (press[1])      press_dir = DIR_UP;
      else if (press[2]) press_dir = DIR_DOWN;
      else if (press[3]) press_dir = DIR_LEFT;
      else if (press[0]) press_dir = DIR_RIGHT;
   end

   assign tick = run && (tick_cnt == TICK_LAST);

   // Tick counter, heading FSM and pending-turn buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt       <= '0;
         state          <= STOPPED;
         move_direction <= 4'b0000;
         move_strobe    <= 1'b0;
         pending_dir    <= 4'b0000;
         age            <= '0;
      end else begin
         move_strobe <= 1'b0;
         if (run) tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);

         if (tick) begin
            if ((pending_dir != 4'b0000) && ((valid_moves & pending_dir) != 4'b0000)) begin
               move_direction <= pending_dir;
               pending_dir    <= 4'b0000;
               age            <= '0;
               state          <= MOVING;
               move_strobe    <= 1'b1;
            end else begin
               if ((state == MOVING) && ((valid_moves & move_direction) != 4'b0000)) begin
                  move_strobe <= 1'b1;
               end else begin
                  move_direction <= 4'b0000;
                  state          <= STOPPED;
               end
               if (pending_dir != 4'b0000) begin
                  if (age >= AGE_LAST) begin
                     pending_dir <= 4'b0000;
                     age         <= '0;
                  end else begin
                     age <= age + AGE_W'(1);
                  end
               end
            end
         end

         // A fresh press wins over any consume/expire on the same edge.
         if (press_dir != 4'b0000) begin
            pending_dir <= press_dir;
            age         <= '0;
         end
      end
   end

endmodule
